csa64_share_arb: RTL
====================

Name: csa64_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one registered 64-bit carry-select adder (CSA64EQG-class, latency ADD_LAT) between two requesters.
- Accepts operand pairs over valid/ready handshakes and issues at most one add per cycle to the adder.
- Tracks the owner of each in-flight add, and returns sum and carry-out to the owning requester through a held response slot with its own handshake.
- Sits between the ALU front-end clients and the shared adder instance, which is external to this block.

Parameters:
- ADD_LAT, 1, adder latency in cycles from adder_issue to adder_sum/adder_cout valid (legal 1..4).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester grant (combinational); at most one bit high.
- req_a0, req_b0  in  64 each  requester 0 operands.
- req_a1, req_b1  in  64 each  requester 1 operands.
- adder_op1, adder_op2  out  64 each  registered operands to the shared adder.
- adder_issue  out  1  registered one-cycle pulse; operands are valid this cycle.
- adder_sum  in  64  adder result.
- adder_cout  in  1  adder carry-out.
- rsp_valid  out  2  per-requester response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_sum0, rsp_sum1  out  64 each  held sum per requester.
- rsp_cout  out  2  held carry-out per requester.
- ops_done  out  CNT_W  count of completed responses; wraps.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - req_ready=0; adder_issue=0; adder_op1/op2=0.
  - rsp_valid=0; rsp_sum*=0; rsp_cout=0; ops_done=0.
  - busy=0; last_grant=1, so requester 0 wins the first tie.
  - All in-flight tags are cleared. Reset mid-operation discards every in-flight result; no rsp_valid appears afterward for it.
- **Eligibility:** elig[i] = req_valid[i] & ~busy[i]. busy[i] is high from the accept edge until the edge at which rsp_valid[i]&rsp_ready[i]. Each requester therefore has at most one outstanding op.
- **Grant:**
  - Only one requester eligible: it is granted.
  - Both eligible: grant goes to ~last_grant.
  - req_ready = grant vector, combinational from elig and last_grant.
  - Handshake = req_valid[i]&req_ready[i] at a rising edge. At that edge: last_grant<=i, busy[i]<=1, adder_op1/op2 <= req_a_i/req_b_i, adder_issue<=1, owner tag i enters the tag pipe.
  - adder_issue is 0 in any cycle not immediately following a handshake.
- **Tag pipe:** ADD_LAT-deep shift register of {valid, id}, advanced every cycle, aligned so that the stage exiting in cycle k+ADD_LAT corresponds to adder_issue in cycle k. At the edge ending cycle k+ADD_LAT: rsp_sum_id<=adder_sum, rsp_cout[id]<=adder_cout, rsp_valid[id]<=1.
- **Latency:** handshake in cycle h → adder_issue in h+1 → rsp_valid in h+2+ADD_LAT (3 cycles after handshake for ADD_LAT=1).
- **Response hold:**
  - rsp_valid[i], rsp_sum_i and rsp_cout[i] stay stable until rsp_ready[i] at an edge.
  - At that edge: rsp_valid[i]<=0, busy[i]<=0, ops_done<=ops_done+1 (mod 2^CNT_W). When both responses complete at the same edge, ops_done increments by 2.
  - The freed requester is eligible from the next cycle; there is no same-cycle response/request bypass.
- **Throughput:** one issue per cycle. With both requesters streaming and rsp_ready tied high, issues are limited by the per-requester single-outstanding rule.
- **Arithmetic:** the block does not modify data. The 65-bit result {cout,sum} is passed through unmodified.
- **Drop-out:** req_valid deasserted without a handshake has no effect. Operands are sampled only at the handshake edge.

Test Plan:
- **Reset:** hold reset=0 for 4 ns at 6 ns period, with req_valid=2'b11 during reset → req_ready=0, adder_issue=0, rsp_valid=0, ops_done=0 throughout.
- **Single op:** requester 0 sends a=64'hbbbb_cdcd_aaaa_1111, b=64'hffff_ffff_ffff_dddd, ADD_LAT=1, with a behavioral adder model → adder_issue one cycle after handshake; rsp_valid[0] 3 cycles after handshake; rsp_sum0=64'hbbbb_cdcd_aaa9_eeee; rsp_cout[0]=1; ops_done=1 after rsp_ready.
- **Tie-break:** both valid in the first cycle after reset, requester 0 a=5,b=7 and requester 1 a=64'hffff_ffff_ffff_ffff,b=1 → grant order 0 then 1 on consecutive cycles; rsp_sum0=12, cout=0; rsp_sum1=0, cout=1; next tie grants requester 0 again (last_grant=1).
- **Backpressure:** rsp_ready[0]=0 for 5 cycles with requester 0 still valid → req_ready[0] stays 0; rsp_sum0 is held stable; requester 1 is still served every time it is eligible.
- **Reset mid-flight:** assert reset=0 the cycle after adder_issue → no rsp_valid afterward; busy is cleared, and a new request after reset completes normally.
- **Latency sweep:** repeat the single op with ADD_LAT=3 → rsp_valid 5 cycles after handshake; data as above.

Source files
------------

// File: rtl/csa64_share_arb.sv
// Round-robin sharing of one external registered 64-bit adder between two requesters;
// issue 1 cycle after handshake, response held per requester until rsp_ready, one op outstanding each.
module csa64_share_arb #(
    parameter int ADD_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [63:0]      req_a0,
    input  logic [63:0]      req_b0,
    input  logic [63:0]      req_a1,
    input  logic [63:0]      req_b1,
    output logic [63:0]      adder_op1,
    output logic [63:0]      adder_op2,
    output logic             adder_issue,
    input  logic [63:0]      adder_sum,
    input  logic             adder_cout,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [63:0]      rsp_sum0,
    output logic [63:0]      rsp_sum1,
    output logic [1:0]       rsp_cout,
    output logic [CNT_W-1:0] ops_done
);

    logic [1:0]         elig;
    logic [1:0]         grant;
    logic               hs_any;
    logic               hs_id;
    logic [1:0]         rsp_done;
    logic [1:0]         ret_mask;

    logic               last_grant_q;
    logic [1:0]         busy_q, busy_d;
    logic [63:0]        op1_q, op2_q;
    logic               issue_q, issue_id_q;
    logic [ADD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [ADD_LAT-1:0] tag_id_q, tag_id_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic [63:0]        sum0_q, sum1_q;
    logic [1:0]         cout_q;
    logic [CNT_W-1:0]   done_q;

    // Grant is gated by reset so nothing is offered while the block is held in reset.
    always_comb begin
        elig  = req_valid & ~busy_q;
        grant = 2'b00;
        if (reset) begin
            if (elig == 2'b11) begin
                grant = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                grant = elig;
            end
        end
    end

    assign hs_any   = |grant;
    assign hs_id    = grant[1];
    assign rsp_done = rsp_valid_q & rsp_ready;

    // The issue register is the head of the tag pipe; the last stage lines up with the adder result.
    always_comb begin
        tag_vld_d[0] = issue_q;
        tag_id_d[0]  = issue_id_q;
        for (int j = 1; j < ADD_LAT; j++) begin
            tag_vld_d[j] = tag_vld_q[j-1];
            tag_id_d[j]  = tag_id_q[j-1];
        end
        ret_mask = 2'b00;
        if (tag_vld_q[ADD_LAT-1]) begin
            ret_mask[tag_id_q[ADD_LAT-1]] = 1'b1;
        end
        busy_d      = (busy_q | grant) & ~rsp_done;
        rsp_valid_d = (rsp_valid_q & ~rsp_done) | ret_mask;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            busy_q       <= 2'b00;
            op1_q        <= '0;
            op2_q        <= '0;
            issue_q      <= 1'b0;
            issue_id_q   <= 1'b0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            rsp_valid_q  <= 2'b00;
            sum0_q       <= '0;
            sum1_q       <= '0;
            cout_q       <= 2'b00;
            done_q       <= '0;
        end else begin
            busy_q      <= busy_d;
            issue_q     <= hs_any;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            if (hs_any) begin
                last_grant_q <= hs_id;
                issue_id_q   <= hs_id;
                op1_q        <= hs_id ? req_a1 : req_a0;
                op2_q        <= hs_id ? req_b1 : req_b0;
            end
            if (ret_mask[0]) begin
                sum0_q    <= adder_sum;
                cout_q[0] <= adder_cout;
            end
            if (ret_mask[1]) begin
                sum1_q    <= adder_sum;
                cout_q[1] <= adder_cout;
            end
            done_q <= done_q + CNT_W'(rsp_done[0]) + CNT_W'(rsp_done[1]);
        end
    end

    assign req_ready   = grant;
    assign adder_op1   = op1_q;
    assign adder_op2   = op2_q;
    assign adder_issue = issue_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_sum0    = sum0_q;
    assign rsp_sum1    = sum1_q;
    assign rsp_cout    = cout_q;
    assign ops_done    = done_q;

endmodule
